// File: rtl/audio_clip_player.sv
// Audio clip player: fetches clip samples from a ROM at a fixed rate and
// hands them to an audio controller FIFO, either once or looped.
// Optional feature: define AUDIO_STEREO_DUP_EN to copy left onto right.
// Ports:
//   CLOCK_50, reset            clock and sync active-high reset
//   start, stop, clip_sel      playback control, clip index
//   loop_en                    repeat selection, latched at start
//   clip_start/end_flat        per-clip inclusive address range table
//   rom_addr, rom_q            ROM address out, ROM data in
//   audio_out_allowed          controller FIFO has room
//   write_audio_out            write strobe to the controller
//   left/right_channel_*       left-justified 32-bit samples
//   playing, done, overrun_cnt status
module audio_clip_player #(
   parameter  int SAMPLE_W  = 6,
   parameter  int ADDR_W    = 16,
   parameter  int NUM_CLIPS = 3,
   parameter  int RATE_DIV  = 2001,
   parameter  int ROM_LAT   = 1,
   parameter  int SIGNED_IN = 0,
   localparam int CIDX_W    = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1
) (
   input  logic                        CLOCK_50,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        stop,
   input  logic [CIDX_W-1:0]           clip_sel,
   input  logic                        loop_en,
   input  logic [NUM_CLIPS*ADDR_W-1:0] clip_start_flat,
   input  logic [NUM_CLIPS*ADDR_W-1:0] clip_end_flat,
   output logic [ADDR_W-1:0]           rom_addr,
   input  logic [SAMPLE_W-1:0]         rom_q,
   input  logic                        audio_out_allowed,
   output logic                        write_audio_out,
   output logic [31:0]                 left_channel_audio_out,
   output logic [31:0]                 right_channel_audio_out,
   output logic                        playing,
   output logic                        done,
   output logic [7:0]                  overrun_cnt
);

   localparam int DIV_W = $clog2(RATE_DIV);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      PRESENT,
      WAIT
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   cstart_q, cstart_d;
   logic [ADDR_W-1:0]   cend_q, cend_d;
   logic                loop_q, loop_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [1:0]          lat_q, lat_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic [31:0]         left_q, left_d;
   logic                done_q, done_d;
   logic [7:0]          ovr_q, ovr_d;

   logic                sel_ok;
   logic [ADDR_W-1:0]   sel_s, sel_e;
   logic                tick, wr;
   logic [SAMPLE_W-1:0] s;
   logic [31:0]         fmt;

   always_comb begin
      sel_ok = 1'b0;
      sel_s  = '0;
      sel_e  = '0;
      for (int i = 0; i < NUM_CLIPS; i++) begin
         if (clip_sel == CIDX_W'(i)) begin
            sel_ok = 1'b1;
            sel_s  = clip_start_flat[i*ADDR_W +: ADDR_W];
            sel_e  = clip_end_flat[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign tick = (div_q == DIV_W'(RATE_DIV - 1));
   assign wr   = (state_q == PRESENT) && audio_out_allowed;

   // offset-binary becomes two's complement by flipping the MSB
   assign s   = (SIGNED_IN != 0) ? sample_q
              : sample_q ^ (SAMPLE_W'(1) << (SAMPLE_W - 1));
   assign fmt = 32'(s) << (32 - SAMPLE_W);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cstart_d = cstart_q;
      cend_d   = cend_q;
      loop_d   = loop_q;
      div_d    = tick ? '0 : div_q + DIV_W'(1);
      lat_d    = lat_q;
      sample_d = sample_q;
      left_d   = wr ? fmt : left_q;
      done_d   = 1'b0;
      ovr_d    = ovr_q;
      if (stop) begin
         state_d = IDLE;
      end else if (start && sel_ok) begin
         cstart_d = sel_s;
         // a reversed range collapses to one sample at start
         cend_d   = (sel_e < sel_s) ? sel_s : sel_e;
         loop_d   = loop_en;
         div_d    = '0;
         lat_d    = '0;
         addr_d   = sel_s;
         state_d  = FETCH;
      end else begin
         unique case (state_q)
            IDLE: ;
            FETCH: begin
               if (tick && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
               // first edge after rom_q settles is ROM_LAT+1 edges in
               if (lat_q == 2'(ROM_LAT)) begin
                  sample_d = rom_q;
                  state_d  = PRESENT;
               end else begin
                  lat_d = lat_q + 2'd1;
               end
            end
            PRESENT: begin
               if (tick && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
               if (wr) state_d = WAIT;
            end
            WAIT: begin
               if (tick) begin
                  lat_d   = '0;
                  state_d = FETCH;
                  if (addr_q != cend_q) begin
                     addr_d = addr_q + ADDR_W'(1);
                  end else if (loop_q) begin
                     addr_d = cstart_q;
                  end else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         cstart_q <= '0;
         cend_q   <= '0;
         loop_q   <= 1'b0;
         div_q    <= '0;
         lat_q    <= '0;
         sample_q <= '0;
         left_q   <= '0;
         done_q   <= 1'b0;
         ovr_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cstart_q <= cstart_d;
         cend_q   <= cend_d;
         loop_q   <= loop_d;
         div_q    <= div_d;
         lat_q    <= lat_d;
         sample_q <= sample_d;
         left_q   <= left_d;
         done_q   <= done_d;
         ovr_q    <= ovr_d;
      end
   end

   assign rom_addr               = addr_q;
   assign write_audio_out        = wr;
   assign left_channel_audio_out = wr ? fmt : left_q;
   assign playing                = (state_q != IDLE);
   assign done                   = done_q;
   assign overrun_cnt            = ovr_q;

`ifdef AUDIO_STEREO_DUP_EN
   assign right_channel_audio_out = left_channel_audio_out;
`else
   assign right_channel_audio_out = 32'd0;
`endif

endmodule

// File: tb/tb_audio_clip_player.sv
// Scoreboard bench for audio_clip_player: directed clip scenarios,
// expected samples queued by stimulus, checked by a write monitor.
module tb_audio_clip_player;

   logic        clk = 1'b0;
   logic        reset, start, stop, loop_en, allowed;
   logic [1:0]  clip_sel;
   logic [47:0] cs_flat, ce_flat;
   logic [15:0] rom_addr;
   logic [5:0]  rom_q = '0;
   logic        wr, playing, done;
   logic [31:0] left, right;
   logic [7:0]  ovr;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_n = 0;
   int done_cyc = 0;
   logic [31:0] expq[$];
   int wcyc[$];

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rom_q <= rom_addr[5:0];

   audio_clip_player #(
      .SAMPLE_W(6), .ADDR_W(16), .NUM_CLIPS(3),
      .RATE_DIV(8), .ROM_LAT(1), .SIGNED_IN(1)
   ) dut (
      .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop),
      .clip_sel(clip_sel), .loop_en(loop_en),
      .clip_start_flat(cs_flat), .clip_end_flat(ce_flat),
      .rom_addr(rom_addr), .rom_q(rom_q),
      .audio_out_allowed(allowed), .write_audio_out(wr),
      .left_channel_audio_out(left),
      .right_channel_audio_out(right),
      .playing(playing), .done(done), .overrun_cnt(ovr)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_n++;
         done_cyc = cyc;
      end
      if (wr === 1'b1) begin
         wcyc.push_back(cyc);
         if (expq.size() == 0) begin
            chk("unexpected_write", left, 32'hDEAD_BEEF);
         end else begin
            logic [31:0] e;
            e = expq.pop_front();
            chk("left", left, e);
`ifdef AUDIO_STEREO_DUP_EN
            chk("right", right, e);
`else
            chk("right", right, 32'd0);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      int dn;
      reset = 1'b1; start = 1'b0; stop = 1'b0;
      loop_en = 1'b0; allowed = 1'b1; clip_sel = 2'd0;
      cs_flat = {16'd10, 16'd4, 16'd0};
      ce_flat = {16'd10, 16'd9, 16'd3};
      step(); step();
      reset = 1'b0;
      chk("rst_addr", 32'(rom_addr), 0);
      chk("rst_play", 32'(playing), 0);
      chk("rst_ovr", 32'(ovr), 0);
      chk("rst_left", left, 0);
      chk("rst_done", 32'(done), 0);

      // clip 0 one-shot
      expq.push_back(32'h0000_0000);
      expq.push_back(32'h0400_0000);
      expq.push_back(32'h0800_0000);
      expq.push_back(32'h0C00_0000);
      wcyc.delete();
      t0 = cyc;
      start = 1'b1; clip_sel = 2'd0; loop_en = 1'b0;
      step();
      start = 1'b0;
      repeat (36) step();
      chk("s1_nwrites", 32'(wcyc.size()), 4);
      for (int i = 0; i < 4 && i < wcyc.size(); i++)
         chk("s1_wcyc", 32'(wcyc[i] - t0), 32'(3 + 8 * i));
      chk("s1_done_n", 32'(done_n), 1);
      chk("s1_done_cyc", 32'(done_cyc - t0), 33);
      chk("s1_play", 32'(playing), 0);

      // clip 2 looped for 40 clocks
      for (int i = 0; i < 5; i++) expq.push_back(32'h2800_0000);
      wcyc.delete();
      start = 1'b1; clip_sel = 2'd2; loop_en = 1'b1;
      step();
      start = 1'b0;
      repeat (39) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("s2_nwrites", 32'(wcyc.size()), 5);
      chk("s2_done_n", 32'(done_n), 1);
      chk("s2_play", 32'(playing), 0);

      // clip 1 with a stalled first sample
      expq.push_back(32'h1000_0000);
      expq.push_back(32'h1400_0000);
      wcyc.delete();
      t0 = cyc;
      start = 1'b1; clip_sel = 2'd1; loop_en = 1'b0;
      allowed = 1'b0;
      step();
      start = 1'b0;
      repeat (11) step();
      allowed = 1'b1;
      repeat (9) step();
      chk("s3_nwrites", 32'(wcyc.size()), 2);
      if (wcyc.size() == 2) begin
         chk("s3_w0", 32'(wcyc[0] - t0), 12);
         chk("s3_w1", 32'(wcyc[1] - t0), 19);
      end
      chk("s3_ovr", 32'(ovr), 1);
      chk("s3_play", 32'(playing), 1);

      // stop and start together
      dn = done_n;
      stop = 1'b1; start = 1'b1; clip_sel = 2'd2;
      step();
      stop = 1'b0; start = 1'b0;
      chk("s4_play", 32'(playing), 0);
      repeat (3) step();
      chk("s4_addr", 32'(rom_addr), 5);
      chk("s4_done", 32'(done_n), 32'(dn));
      // out-of-range clip index
      start = 1'b1; clip_sel = 2'd3;
      step();
      start = 1'b0;
      chk("s4_bad_sel", 32'(playing), 0);
      repeat (3) step();
      chk("s4_bad_sel2", 32'(playing), 0);
      chk("s4_addr2", 32'(rom_addr), 5);

      // reset mid clip 1
      expq.push_back(32'h1000_0000);
      start = 1'b1; clip_sel = 2'd1; loop_en = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      chk("s5_play_pre", 32'(playing), 1);
      reset = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      chk("s5_addr", 32'(rom_addr), 0);
      chk("s5_play", 32'(playing), 0);
      chk("s5_left", left, 0);
      chk("s5_right", right, 0);
      chk("s5_ovr", 32'(ovr), 0);
      chk("s5_done", 32'(done), 0);
      chk("s5_wr", 32'(wr), 0);
      reset = 1'b0;
      repeat (20) step();
      chk("s5_done_n", 32'(done_n), 32'(dn));
      chk("s5_idle", 32'(playing), 0);
      chk("queue_empty", 32'(expq.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
